// File: rtl/spi_tx_shifter.sv
// spi_tx_shifter
//   Serialising stage that sits directly after the single-entry output FIFO.
//   It accepts one FWIDTH-bit byte over the FIFO's active-low
//   ready / loading / data-ready handshake. It then shifts the byte out
//   MSB-first as an SPI mode-0 master (SCLK idles low). At the same time it
//   captures MISO into a receive register.
//
// Handshake (active-low, both sides registered):
//   The block advertises SPITX_RcvrRdyN=0 while idle and enabled. A byte
//   transfers on the edge where SPITX_RcvrRdyN=0 and SPITX_DataRdyN=0 are
//   both sampled. The block then holds SPITX_RcvrLoadingN=0, which the FIFO
//   reports as Full, until the FIFO releases its entry (SPITX_DataRdyN
//   sampled 1). Only then does the shift start.
//
// Ports:
//   SPITX_Clk, SPITX_Rst     clock, synchronous active-high reset
//   SPITX_En                 gates advertising ready; never aborts a transfer
//   SPITX_Data_In            byte from FIFO, sampled only on the IDLE->LOAD edge
//   SPITX_DataRdyN           FIFO holds a byte (active-low)
//   SPITX_RcvrRdyN           block can accept a byte (active-low)
//   SPITX_RcvrLoadingN       byte captured, FIFO entry not yet released
//   SPITX_Sclk/Mosi/Miso/CsN SPI master pins
//   SPITX_RxData/RxValid     last received byte and its one-cycle strobe
//   SPITX_Busy               high in any state other than IDLE
module spi_tx_shifter #(
  parameter int FWIDTH = 8,
  parameter int CLKDIV = 2
) (
  input  logic              SPITX_Clk,
  input  logic              SPITX_Rst,
  input  logic              SPITX_En,
  input  logic [FWIDTH-1:0] SPITX_Data_In,
  input  logic              SPITX_DataRdyN,
  output logic              SPITX_RcvrRdyN,
  output logic              SPITX_RcvrLoadingN,
  output logic              SPITX_Sclk,
  output logic              SPITX_Mosi,
  input  logic              SPITX_Miso,
  output logic              SPITX_CsN,
  output logic [FWIDTH-1:0] SPITX_RxData,
  output logic              SPITX_RxValid,
  output logic              SPITX_Busy
);

  localparam int DIVW = $clog2(2 * CLKDIV);
  localparam int BW   = $clog2(FWIDTH + 1);

  localparam logic [DIVW-1:0] DIV_HALF = DIVW'(CLKDIV - 1);
  localparam logic [DIVW-1:0] DIV_FULL = DIVW'(2 * CLKDIV - 1);
  localparam logic [BW-1:0]   BIT_LAST = BW'(FWIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              rdy_n_q, rdy_n_d;
  logic              loading_n_q, loading_n_d;
  logic              cs_n_q, cs_n_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic [FWIDTH-1:0] shift_q, shift_d;
  logic [FWIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [FWIDTH-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic [DIVW-1:0]   div_q, div_d;
  logic [BW-1:0]     bit_q, bit_d;

  always_comb begin
    state_d     = state_q;
    rdy_n_d     = rdy_n_q;
    loading_n_d = loading_n_q;
    cs_n_d      = cs_n_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    shift_d     = shift_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    div_d       = div_q;
    bit_d       = bit_q;

    case (state_q)
      S_IDLE: begin
        rdy_n_d = ~SPITX_En;
        if (!rdy_n_q && !SPITX_DataRdyN) begin
          shift_d     = SPITX_Data_In;
          rdy_n_d     = 1'b1;
          loading_n_d = 1'b0;
          state_d     = S_LOAD;
        end
      end

      S_LOAD: begin
        if (SPITX_DataRdyN) begin
          loading_n_d = 1'b1;
          cs_n_d      = 1'b0;
          mosi_d      = shift_q[FWIDTH-1];
          div_d       = '0;
          bit_d       = '0;
          state_d     = S_SHIFT;
        end
      end

      S_SHIFT: begin
        div_d = div_q + 1'b1;
        // Rising SCLK half-way through the bit: MISO is sampled here.
        if (div_q == DIV_HALF) begin
          sclk_d     = 1'b1;
          rx_shift_d = {rx_shift_q[FWIDTH-2:0], SPITX_Miso};
        end
        // Falling SCLK ends the bit. MOSI changes only here, so it is stable
        // across every rising edge.
        if (div_q == DIV_FULL) begin
          sclk_d = 1'b0;
          div_d  = '0;
          bit_d  = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
            // The DONE-cycle outputs are registered on entry. CsN, Mosi,
            // RxData and RxValid are therefore already valid during the
            // single DONE cycle, and CsN is low for exactly the SHIFT length.
            cs_n_d     = 1'b1;
            mosi_d     = 1'b1;
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            shift_d = {shift_q[FWIDTH-2:0], 1'b0};
            mosi_d  = shift_q[FWIDTH-2];
          end
        end
      end

      S_DONE: begin
        // Ready is already asserted during the first IDLE cycle.
        rdy_n_d = ~SPITX_En;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge SPITX_Clk) begin
    if (SPITX_Rst) begin
      state_q     <= S_IDLE;
      rdy_n_q     <= 1'b1;
      loading_n_q <= 1'b1;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b1;
      shift_q     <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      div_q       <= '0;
      bit_q       <= '0;
    end else begin
      state_q     <= state_d;
      rdy_n_q     <= rdy_n_d;
      loading_n_q <= loading_n_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      shift_q     <= shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
    end
  end

  assign SPITX_RcvrRdyN     = rdy_n_q;
  assign SPITX_RcvrLoadingN = loading_n_q;
  assign SPITX_CsN          = cs_n_q;
  assign SPITX_Sclk         = sclk_q;
  assign SPITX_Mosi         = mosi_q;
  assign SPITX_RxData       = rx_data_q;
  assign SPITX_RxValid      = rx_valid_q;
  assign SPITX_Busy         = (state_q != S_IDLE);

endmodule

// File: doc/spi_tx_shifter.md
Name: spi_tx_shifter

Overview:
- Serialising stage directly downstream of the single-entry output FIFO.
- Takes one FWIDTH-bit byte per handshake over the FIFO's ready/loading/data-ready interface and shifts it out MSB-first as an SPI mode-0 master (SCLK idle low).
- Captures MISO into a receive register at the same time and pulses a valid strobe when the byte completes.
- Its RcvrRdyN and RcvrLoadingN outputs drive the FIFO's receiver inputs; the FIFO's DataRdyN and Data_Out drive this block.

Parameters:
- FWIDTH, 8, data width in bits; also the bit count per transfer.
- CLKDIV, 2, system clocks per SCLK half-period; legal range 1..255.

Ports:
- SPITX_Clk  in  1  system clock; the only clock.
- SPITX_Rst  in  1  synchronous, active-high reset.
- SPITX_En  in  1  when low, the block does not advertise ready; a transfer already in progress completes.
- SPITX_Data_In  in  FWIDTH  byte from the FIFO; valid while SPITX_DataRdyN=0.
- SPITX_DataRdyN  in  1  active-low: FIFO holds a byte for this block.
- SPITX_RcvrRdyN  out  1  active-low: block can accept a byte.
- SPITX_RcvrLoadingN  out  1  active-low: byte captured and handshake not yet released; makes the FIFO report Full.
- SPITX_Sclk  out  1  SPI clock.
- SPITX_Mosi  out  1  serial data out.
- SPITX_Miso  in  1  serial data in.
- SPITX_CsN  out  1  active-low chip select.
- SPITX_RxData  out  FWIDTH  last received byte.
- SPITX_RxValid  out  1  one-cycle pulse when SPITX_RxData updates.
- SPITX_Busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: the following values apply on the first rising edge with SPITX_Rst=1, including mid-transfer; state returns to IDLE.
  - RcvrRdyN=1, RcvrLoadingN=1, CsN=1, Sclk=0, Mosi=1.
  - RxData=0, RxValid=0, Busy=0, counters=0.
- State IDLE:
  - RcvrRdyN = ~SPITX_En (registered).
  - If RcvrRdyN=0 and DataRdyN=0 are sampled on the same edge: shift register <= Data_In, RcvrRdyN<=1, RcvrLoadingN<=0, go to LOAD.
  - DataRdyN=0 while RcvrRdyN=1 is ignored.
- State LOAD:
  - Hold RcvrLoadingN=0 and RcvrRdyN=1; wait for DataRdyN sampled 1 (FIFO released its entry).
  - Then: RcvrLoadingN<=1, CsN<=0, Mosi<=shift register MSB, div counter=0, bit counter=0, go to SHIFT.
  - No timeout; only reset exits LOAD.
- State SHIFT: each bit lasts 2*CLKDIV clocks.
  - After CLKDIV clocks: Sclk<=1; sample Miso into the receive shift register LSB (left shift).
  - After 2*CLKDIV clocks: Sclk<=0; bit counter++.
  - If the bit counter is below FWIDTH: Mosi<=next bit and the div counter restarts.
  - After the FWIDTH-th falling edge: go to DONE.
  - Total SHIFT duration = FWIDTH*2*CLKDIV clocks.
- State DONE, one cycle:
  - CsN<=1, Mosi<=1, RxData<=receive register, RxValid<=1 for exactly this cycle.
  - Next state IDLE; RcvrRdyN re-asserts on the IDLE cycle if En=1.
- Minimum throughput gap: IDLE→LOAD→SHIFT→DONE→IDLE.
- Overhead is at least 3 clocks beyond SHIFT, plus FIFO handshake time.
- En deasserted during LOAD/SHIFT/DONE has no effect until IDLE.
- Data_In is sampled only on the IDLE→LOAD edge; later changes are ignored.
- Sclk stays 0 outside SHIFT; no glitch on entering or leaving SHIFT.

Test Plan:
- Reset then idle, En=1 → RcvrRdyN=0 one cycle after reset release; CsN=1, Sclk=0, Mosi=1, RxValid=0.
- FIFO presents 0xA5, Miso driven 0x3C MSB-first (changed on SCLK falling edges), CLKDIV=2 → MOSI bits 1,0,1,0,0,1,0,1 at each rising Sclk; SHIFT lasts 32 clocks; RxData=0x3C with a single-cycle RxValid; CsN low for exactly 32 clocks.
- Handshake: DataRdyN=0 → RcvrLoadingN=0 and RcvrRdyN=1 the next cycle; hold DataRdyN=0 for 5 cycles → stays in LOAD, CsN=1; DataRdyN=1 → CsN=0 and RcvrLoadingN=1 on the following edge.
- Back-to-back bytes 0xFF then 0x00 with the FIFO refilled immediately → two complete frames; CsN high for at least 1 clock between frames; RxValid pulses twice.
- En=0 with DataRdyN=0 → RcvrRdyN stays 1, no transfer; En dropped mid-SHIFT → current frame completes, then RcvrRdyN=1.
- Reset asserted at bit 4 of a transfer → next cycle CsN=1, Sclk=0, RcvrLoadingN=1, Busy=0, RxValid never pulses.
